// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared bus defines for the pipeline controller.
//   - Hold levels (Hold_None < Hold_Pc < Hold_If < Hold_Id). A higher level
//     freezes more of the front end.
//   - Bus widths: Hold_Flag_Bus (3 bits) and InstAddrBus (32 bits).
//   - Controller FSM state encoding (RUN / PEND / FLUSH).
package pipe_ctrl_pkg;

  localparam int HOLD_FLAG_W = 3;
  localparam int INST_ADDR_W = 32;
  localparam int STATE_W     = 2;
  localparam int FLUSH_CNT_W = 3;

  // Hold levels. The numeric order is meaningful: the merged hold is the
  // highest level requested by any source.
  localparam logic [HOLD_FLAG_W-1:0] Hold_None = 3'b000;
  localparam logic [HOLD_FLAG_W-1:0] Hold_Pc   = 3'b001;
  localparam logic [HOLD_FLAG_W-1:0] Hold_If   = 3'b010;
  localparam logic [HOLD_FLAG_W-1:0] Hold_Id   = 3'b011;

  // Controller states.
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd0;
  localparam logic [STATE_W-1:0] ST_PEND  = 2'd1;
  localparam logic [STATE_W-1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/pipe_ctrl_timeout_cnt.sv
// ctrl_timeout_cnt: bus-hold watchdog.
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-low reset
//   hold_i    in  : bus arbiter is holding the PC this cycle
//   timeout_o out : one-cycle pulse in the TIMEOUT_CYCLES-th consecutive
//                   hold cycle; no further pulses until hold_i drops
// Only instantiated when CTRL_BUS_TIMEOUT_EN is defined.
module ctrl_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  output logic timeout_o
);

  localparam logic [15:0] Limit = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // cnt_q counts completed hold cycles; it saturates at Limit so the pulse
  // cannot repeat during one long hold.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      cnt_d = 16'd0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current hold cycle is number cnt_q + 1.
  assign timeout_o = hold_i && (cnt_q == Limit - 16'd1);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline controller. Merges stall sources into one hold level,
// issues PC redirects (interrupt beats jump), defers a redirect while the bus
// holds the PC, and keeps Hold_Id up for FLUSH_CYCLES extra cycles after each
// issued redirect to squash stale fetch slots.
// Ports:
//   clk, rst (sync, active-low)
//   jump_flag_i/jump_addr_i   : execute redirect request / target
//   hold_ex_i                 : execute multi-cycle stall
//   hold_rib_i                : bus arbiter holds the PC
//   int_assert_i/int_addr_i   : interrupt redirect request / target
//   halt_i                    : debug halt
//   hold_flag_o               : merged hold level
//   jump_flag_o/jump_addr_o   : PC load strobe / value (combinational)
//   bus_timeout_o             : bus-hold watchdog pulse
//   dbg_state_o               : current FSM state, for observation only
// Parameters: FLUSH_CYCLES (0..7), TIMEOUT_CYCLES (1..65535).
// Build option: CTRL_BUS_TIMEOUT_EN enables the bus-hold watchdog; without it
// bus_timeout_o is tied low.
//
// Handshake note: there is no backpressure on redirects. A redirect input is
// consumed in the cycle it is seen; if hold_rib_i is high it is parked in
// pend_addr (newest request wins) and issued in the first cycle hold_rib_i is
// low, where a fresh redirect request in that cycle takes precedence.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic                   hold_ex_i,
  input  logic                   hold_rib_i,
  input  logic                   int_assert_i,
  input  logic [INST_ADDR_W-1:0] int_addr_i,
  input  logic                   halt_i,
  output logic [HOLD_FLAG_W-1:0] hold_flag_o,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic                   bus_timeout_o,
  output logic [STATE_W-1:0]     dbg_state_o
);

  localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [INST_ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic                   redir_req;
  logic [INST_ADDR_W-1:0] redir_addr;

  assign redir_req  = int_assert_i | jump_flag_i;
  assign redir_addr = int_assert_i ? int_addr_i : jump_addr_i;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    flush_cnt_d = flush_cnt_q;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;

    if (state_q == ST_PEND) begin
      if (hold_rib_i) begin
        if (redir_req) begin
          pend_addr_d = redir_addr;
        end
      end else begin
        jump_flag_o = 1'b1;
        jump_addr_o = redir_req ? redir_addr : pend_addr_q;
      end
    end else if (redir_req) begin
      // RUN and FLUSH treat a new redirect identically.
      if (hold_rib_i) begin
        pend_addr_d = redir_addr;
        state_d     = ST_PEND;
      end else begin
        jump_flag_o = 1'b1;
        jump_addr_o = redir_addr;
      end
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
        state_d = ST_RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
      end
    end

    // Every issued redirect (re)starts the flush window.
    if (jump_flag_o) begin
      if (FLUSH_CYCLES == 0) begin
        state_d = ST_RUN;
      end else begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FlushLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      pend_addr_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // A pending redirect being issued implies state PEND, so the PEND term
  // already covers that case.
  always_comb begin
    if (redir_req || hold_ex_i || (state_q != ST_RUN)) begin
      hold_flag_o = Hold_Id;
    end else if (hold_rib_i || halt_i) begin
      hold_flag_o = Hold_Pc;
    end else begin
      hold_flag_o = Hold_None;
    end
  end

  assign dbg_state_o = state_q;

`ifdef CTRL_BUS_TIMEOUT_EN
  ctrl_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (hold_rib_i),
    .timeout_o(bus_timeout_o)
  );
`else
  assign bus_timeout_o = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller that sequences the fetch/decode pipeline registers. It merges stall requests from execute, the bus arbiter, the interrupt controller and the debug halt line into the single `hold_flag_o` level consumed by the PC register, the IF/ID and ID/EX stages. It owns PC redirection: it issues the jump/interrupt target to the PC. It also defers a redirect that arrives while the bus holds the PC, and flushes the stale fetch slots that follow a redirect.

## Interface
- `FLUSH_CYCLES`, default 1: extra cycles of `Hold_Id` after a redirect is issued, to cover synchronous instruction-memory latency (0..7).
- `TIMEOUT_CYCLES`, default 255: consecutive bus-hold cycles before `bus_timeout_o` fires (1..65535).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `jump_flag_i` in 1: execute requests a redirect.
- `jump_addr_i` in `InstAddrBus`: execute redirect target.
- `hold_ex_i` in 1: execute multi-cycle stall.
- `hold_rib_i` in 1: bus arbiter holds the PC.
- `int_assert_i` in 1: interrupt controller redirect.
- `int_addr_i` in `InstAddrBus`: trap vector / mepc.
- `halt_i` in 1: debug halt.
- `hold_flag_o` out `Hold_Flag_Bus`: merged hold level.
- `jump_flag_o` out 1: PC load strobe.
- `jump_addr_o` out `InstAddrBus`: PC load value.
- `bus_timeout_o` out 1: one-cycle pulse on bus-hold timeout.

## Operation
- State machine with three states: RUN, PEND and FLUSH. Reset enters RUN and clears `pend_addr`, the flush counter and the timeout counter.
- Redirect source: `int_assert_i` beats `jump_flag_i`. The address comes from the winning source.
- RUN, redirect present, `hold_rib_i`=0:
  - `jump_flag_o`=1, `jump_addr_o`=target (combinational, same cycle).
  - Next state is FLUSH with counter=`FLUSH_CYCLES`, or RUN if `FLUSH_CYCLES`=0.
- RUN, redirect present, `hold_rib_i`=1:
  - `jump_flag_o`=0; latch target into `pend_addr`; next state is PEND.
- PEND:
  - While `hold_rib_i`=1, stay. A new redirect overwrites `pend_addr`, with interrupt priority.
  - On `hold_rib_i`=0: issue `jump_flag_o`=1, `jump_addr_o`=`pend_addr`, unless a redirect input is also present that cycle, in which case that input wins. Then go to FLUSH or RUN as above.
- FLUSH: the counter decrements each cycle and the state returns to RUN at 1. A new redirect in FLUSH behaves exactly as a redirect in RUN and reloads the counter.
- `hold_flag_o` is the maximum of these terms:
  - `Hold_Id` if a redirect input is asserted, `hold_ex_i`=1, state is PEND, state is FLUSH, or a pending redirect is issued this cycle.
  - `Hold_Pc` if `hold_rib_i`=1 or `halt_i`=1.
  - Otherwise `Hold_None`.
- `halt_i` never blocks redirect acceptance. Only `hold_rib_i` defers a redirect.

## Timing
- Every output is a combinational function of the inputs and registered state. No input-to-state loop.
- Reset values: `hold_flag_o`=`Hold_None`, `jump_flag_o`=0, `jump_addr_o`=0, `bus_timeout_o`=0. This holds when all inputs are idle during reset.
- Redirect-to-PC latency is 0 cycles when the bus is free. When the bus is held, the redirect issues in the first cycle `hold_rib_i` is low.
- The IF/ID stage sees `Hold_Id` for 1 + `FLUSH_CYCLES` cycles per issued redirect.
- Reset asserted mid-PEND or mid-FLUSH discards the pending target and the counter. No redirect issues after reset.

## Configuration
- `CTRL_BUS_TIMEOUT_EN` defined:
  - A 16-bit counter increments every cycle `hold_rib_i`=1 and clears when it is 0.
  - `bus_timeout_o` pulses for one cycle when the count reaches `TIMEOUT_CYCLES`.
  - The counter then saturates, with no further pulses, until `hold_rib_i` drops.
- `CTRL_BUS_TIMEOUT_EN` undefined: `bus_timeout_o` is tied 0, no counter exists, and the port remains.

## Structure
- `Hold_None`/`Hold_Pc`/`Hold_If`/`Hold_Id`, the `Hold_Flag_Bus` and `InstAddrBus` widths, and the state encoding constants go in the shared bus-defines package.
- Sub-module `ctrl_timeout_cnt` holds the watchdog counter. It is instantiated only under `CTRL_BUS_TIMEOUT_EN`.
- Registered state uses the shared pipeline DFF primitives.

## Test plan
- `jump_flag_i`=1, `jump_addr_i`=0x100, bus free, `FLUSH_CYCLES`=1 -> `jump_flag_o`=1 with addr 0x100 that cycle; `hold_flag_o`=`Hold_Id` for 2 cycles, then `Hold_None`.
- `hold_rib_i`=1 for 3 cycles with a jump to 0x200 in the first -> `hold_flag_o`=`Hold_Id` throughout, `jump_flag_o`=0; in cycle 4 `jump_flag_o`=1 with addr 0x200.
- Simultaneous `int_assert_i` (0x80) and `jump_flag_i` (0x300) -> `jump_addr_o`=0x80. During PEND, an interrupt overwrites pending 0x300 with 0x80.
- `hold_ex_i`=1 with `halt_i`=1 -> `Hold_Id`. `halt_i` alone -> `Hold_Pc`, and a jump is still issued.
- Reset (`rst`=0) in PEND with pending 0x400, then bus released -> no `jump_flag_o`, and `hold_flag_o`=`Hold_None`.
- With `CTRL_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4: `hold_rib_i` high for 10 cycles -> one pulse at cycle 4 only. Drop the bus hold, re-raise it for 4 cycles -> a second pulse.
